// File: rtl/router_pkg.sv
// Shared types and helpers for the router egress path: FSM encoding, header
// layout and the rotating-priority channel search used by the egress arbiter.
package router_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int HDR_LEN_LSB = 2;
  localparam int NUM_CH      = 3;

  typedef struct packed {
    logic       found;
    logic [1:0] pick;
  } rr_pick_t;

  // Farthest candidate is visited first so the nearest non-empty one wins.
  function automatic rr_pick_t next_rr(input logic [1:0] grant, input logic [2:0] empty);
    rr_pick_t   r;
    logic [1:0] ch;
    r.found = 1'b0;
    r.pick  = grant;
    for (int k = NUM_CH; k >= 1; k--) begin
      ch = 2'((int'(grant) + k) % NUM_CH);
      if (!empty[ch]) begin
        r.found = 1'b1;
        r.pick  = ch;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/router_rr_pick.sv
// Combinational 3-way rotating-priority picker: searches from grant+1 for the
// first channel whose empty bit is clear.
module router_rr_pick
  import router_pkg::*;
(
  input  logic [1:0] grant_i,
  input  logic [2:0] empty_i,
  output logic       found_o,
  output logic [1:0] pick_o
);

  rr_pick_t pick_res;

  always_comb pick_res = next_rr(grant_i, empty_i);

  assign found_o = pick_res.found;
  assign pick_o  = pick_res.pick;

endmodule

// File: rtl/router_egress_arb.sv
// Round-robin egress scheduler for the three router FIFOs: moves one whole
// packet at a time onto a valid/ready link, flushing a FIFO whose packet stalls.
module router_egress_arb
  import router_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 30,
  parameter int TCNT_W  = 5
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             fifo_empty_0,
  input  logic             fifo_empty_1,
  input  logic             fifo_empty_2,
  input  logic [WIDTH-1:0] data_out_0,
  input  logic [WIDTH-1:0] data_out_1,
  input  logic [WIDTH-1:0] data_out_2,
  output logic             read_enb_0,
  output logic             read_enb_1,
  output logic             read_enb_2,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             soft_reset_0,
  output logic             soft_reset_1,
  output logic             soft_reset_2,
  output logic [1:0]       grant,
  output logic             busy
);

  localparam int REM_W = WIDTH - HDR_LEN_LSB + 1;

  state_e             state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic               rd_pend_q, rd_pend_d;
  logic               hdr_seen_q, hdr_seen_d;
  logic [REM_W-1:0]   remaining_q, remaining_d;
  logic [TCNT_W-1:0]  wdog_q, wdog_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic [2:0]         soft_reset_q, soft_reset_d;

  logic [2:0]         empty_vec;
  logic [2:0]         rd_en;
  logic               empty_g;
  logic [WIDTH-1:0]   data_g;
  logic               rd_issue;
  logic               stall;
  logic               handshake;
  logic               pick_found;
  logic [1:0]         pick_ch;

  assign empty_vec = {fifo_empty_2, fifo_empty_1, fifo_empty_0};

  always_comb begin
    empty_g = fifo_empty_0;
    data_g  = data_out_0;
    case (grant_q)
      2'd1: begin
        empty_g = fifo_empty_1;
        data_g  = data_out_1;
      end
      2'd2: begin
        empty_g = fifo_empty_2;
        data_g  = data_out_2;
      end
      default: ;
    endcase
  end

  // A channel being flushed this cycle may still look non-empty; skip it.
  router_rr_pick u_pick (
    .grant_i (grant_q),
    .empty_i (empty_vec | soft_reset_q),
    .found_o (pick_found),
    .pick_o  (pick_ch)
  );

  assign stall     = out_valid_q && !out_ready;
  assign handshake = out_valid_q && out_ready;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rd_pend_d    = rd_pend_q;
    hdr_seen_d   = hdr_seen_q;
    remaining_d  = remaining_q;
    wdog_d       = wdog_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    soft_reset_d = 3'b000;
    rd_issue     = 1'b0;

    case (state_q)
      IDLE: begin
        wdog_d      = '0;
        rd_pend_d   = 1'b0;
        out_valid_d = 1'b0;
        if (pick_found) begin
          grant_d    = pick_ch;
          hdr_seen_d = 1'b0;
          state_d    = XFER;
        end
      end

      XFER, DRAIN: begin
        if (handshake) out_valid_d = 1'b0;

        if (state_q == XFER) begin
          // A read is only issued when the output slot will be free on load.
          rd_issue  = !rd_pend_q && !empty_g && (!hdr_seen_q || remaining_q != '0) &&
                      (!out_valid_q || out_ready);
          rd_pend_d = rd_issue;
          if (rd_pend_q) begin
            out_data_d  = data_g;
            out_valid_d = 1'b1;
            if (!hdr_seen_q) begin
              hdr_seen_d  = 1'b1;
              remaining_d = REM_W'(data_g >> HDR_LEN_LSB) + REM_W'(1);
            end else begin
              remaining_d = remaining_q - 1'b1;
            end
          end
          if (hdr_seen_q && remaining_q == '0 && !rd_pend_q) state_d = DRAIN;
        end else if (!out_valid_q || out_ready) begin
          state_d = IDLE;
        end

        if (handshake) begin
          wdog_d = '0;
        end else if (stall) begin
          if (wdog_q == TCNT_W'(TIMEOUT - 1)) begin
            soft_reset_d = 3'b001 << grant_q;
            out_valid_d  = 1'b0;
            rd_pend_d    = 1'b0;
            wdog_d       = '0;
            state_d      = IDLE;
          end else begin
            wdog_d = wdog_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign rd_en = rd_issue ? (3'b001 << grant_q) : 3'b000;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= IDLE;
      grant_q      <= 2'd2;
      rd_pend_q    <= 1'b0;
      hdr_seen_q   <= 1'b0;
      remaining_q  <= '0;
      wdog_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      soft_reset_q <= 3'b000;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rd_pend_q    <= rd_pend_d;
      hdr_seen_q   <= hdr_seen_d;
      remaining_q  <= remaining_d;
      wdog_q       <= wdog_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      soft_reset_q <= soft_reset_d;
    end
  end

  assign read_enb_0   = rd_en[0];
  assign read_enb_1   = rd_en[1];
  assign read_enb_2   = rd_en[2];
  assign soft_reset_0 = soft_reset_q[0];
  assign soft_reset_1 = soft_reset_q[1];
  assign soft_reset_2 = soft_reset_q[2];
  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign grant        = grant_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_router_egress_arb.sv
// Bench for router_egress_arb: FIFO models, a packet-level round-robin
// scoreboard, a single-packet vector table and hand-written corner sequences.
module tb_router_egress_arb;

  logic       clock, resetn;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic [7:0] data_out_0, data_out_1, data_out_2;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic [7:0] out_data;
  logic       out_valid, out_ready;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic [1:0] grant;
  logic       busy;

  router_egress_arb #(.WIDTH(8), .TIMEOUT(30), .TCNT_W(5)) dut (
    .clock(clock), .resetn(resetn),
    .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
    .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
    .grant(grant), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { logic [7:0] hdr; int id; } pkt_t;
  typedef struct { logic [7:0] data; logic [1:0] ch; bit hdr; } exp_t;
  typedef struct { int ch; logic [7:0] hdr; int beats; } vec_t;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, beats = 0, hs_cnt = 0, last_hs_cyc = 0, bad_read = 0;
  int m_last = 2, next_id = 1;
  logic [7:0] fq0[$], fq1[$], fq2[$];
  pkt_t pq0[$], pq1[$], pq2[$];
  exp_t exp_q[$];
  logic [1:0] got_grants[$];

  logic       s_valid, s_ready, s_busy;
  logic [7:0] s_data, prev_data;
  logic [2:0] s_rd, s_sr, sr_seen;
  logic [1:0] s_grant;
  bit         hs, sb_en = 0, hold_chk = 0, prev_stall = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  function automatic logic [7:0] pbyte(input int id, input int k);
    return 8'(id * 37 + k * 11 + 3);
  endfunction

  task automatic upd_empty();
    fifo_empty_0 = (fq0.size() == 0);
    fifo_empty_1 = (fq1.size() == 0);
    fifo_empty_2 = (fq2.size() == 0);
  endtask

  // One clock: sample at the falling edge, then apply FIFO reads/flushes after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clock);
    cyc++;
    s_valid = out_valid; s_ready = out_ready; s_data = out_data;
    s_rd    = {read_enb_2, read_enb_1, read_enb_0};
    s_sr    = {soft_reset_2, soft_reset_1, soft_reset_0};
    s_grant = grant; s_busy = busy;
    hs = s_valid && s_ready;
    sr_seen = sr_seen | s_sr;
    if (s_rd != 3'b000 && s_rd != (3'b001 << s_grant)) bad_read++;
    if (hs) begin beats++; hs_cnt++; last_hs_cyc = cyc; end
    if (sb_en && hs) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL extra_beat: got data %0h on grant %0d, expected no beat", s_data, s_grant);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", s_data, e.data);
        chk("beat_grant", s_grant, e.ch);
        if (e.hdr) got_grants.push_back(s_grant);
      end
    end
    if (hold_chk && prev_stall) begin
      chk("hold_valid", s_valid, 1);
      chk("hold_data", s_data, prev_data);
    end
    prev_stall = s_valid && !s_ready;
    prev_data  = s_data;
    @(posedge clock); #1;
    if (s_rd[0]) begin if (fq0.size() == 0) bad_read++; else data_out_0 = fq0.pop_front(); end
    if (s_rd[1]) begin if (fq1.size() == 0) bad_read++; else data_out_1 = fq1.pop_front(); end
    if (s_rd[2]) begin if (fq2.size() == 0) bad_read++; else data_out_2 = fq2.pop_front(); end
    if (s_sr[0]) fq0.delete();
    if (s_sr[1]) fq1.delete();
    if (s_sr[2]) fq2.delete();
    upd_empty();
  endtask

  task automatic push_pkt(input int ch, input logic [7:0] hdr);
    pkt_t p;
    logic [7:0] b;
    p.hdr = hdr; p.id = next_id++;
    for (int k = -1; k <= int'(hdr[7:2]); k++) begin
      b = (k < 0) ? hdr : pbyte(p.id, k);
      case (ch)
        0: fq0.push_back(b);
        1: fq1.push_back(b);
        default: fq2.push_back(b);
      endcase
    end
    case (ch)
      0: pq0.push_back(p);
      1: pq1.push_back(p);
      default: pq2.push_back(p);
    endcase
    upd_empty();
  endtask

  function automatic int pend_size(input int ch);
    case (ch)
      0: return pq0.size();
      1: return pq1.size();
      default: return pq2.size();
    endcase
  endfunction

  // Expected egress stream: whole packets, channels visited round-robin after the last owner.
  task automatic plan();
    pkt_t p;
    exp_t e;
    int c, cc;
    bit f;
    while (pend_size(0) + pend_size(1) + pend_size(2) > 0) begin
      f = 0; c = 0;
      for (int k = 1; k <= 3; k++) begin
        cc = (m_last + k) % 3;
        if (!f && pend_size(cc) > 0) begin f = 1; c = cc; end
      end
      case (c)
        0: p = pq0.pop_front();
        1: p = pq1.pop_front();
        default: p = pq2.pop_front();
      endcase
      e.ch = 2'(c); e.hdr = 1; e.data = p.hdr;
      exp_q.push_back(e);
      e.hdr = 0;
      for (int k = 0; k <= int'(p.hdr[7:2]); k++) begin
        e.data = pbyte(p.id, k);
        exp_q.push_back(e);
      end
      m_last = c;
    end
  endtask

  task automatic clear_all();
    fq0.delete(); fq1.delete(); fq2.delete();
    pq0.delete(); pq1.delete(); pq2.delete();
    exp_q.delete(); got_grants.delete();
    data_out_0 = 8'h00; data_out_1 = 8'h00; data_out_2 = 8'h00;
    upd_empty();
    m_last = 2; sr_seen = 3'b000; beats = 0; hs_cnt = 0; prev_stall = 0;
  endtask

  task automatic do_reset();
    resetn = 1'b0; out_ready = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    clear_all();
  endtask

  task automatic run_done(input int budget, input int pct);
    int n = 0;
    do begin
      out_ready = ($urandom_range(0, 99) < pct);
      tick();
      n++;
    end while ((exp_q.size() != 0 || s_busy) && n < budget);
    chk("all_delivered", exp_q.size(), 0);
    chk("idle_at_end", s_busy, 0);
  endtask

  initial begin
    vec_t vt[5];
    logic [1:0] rr_exp[5];
    int n, stall;

    #600000;
    $display("FAIL global_timeout: got no finish, expected finish before time limit");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    vec_t vt[5];
    logic [1:0] rr_exp[5];
    int n, stall;

    resetn = 1'b0; out_ready = 1'b0;
    data_out_0 = 8'h00; data_out_1 = 8'h00; data_out_2 = 8'h00;
    fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;

    // Reset state
    do_reset();
    tick();
    chk("rst_valid", s_valid, 0);
    chk("rst_read_enb", s_rd, 0);
    chk("rst_soft_reset", s_sr, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_out_data", s_data, 0);
    chk("rst_grant", s_grant, 2);

    // Single packets: {channel, header, total beats = len + 2}
    vt[0] = '{0, 8'h0C, 5};
    vt[1] = '{1, 8'h01, 2};
    vt[2] = '{2, 8'hFF, 65};
    vt[3] = '{1, 8'h10, 6};
    vt[4] = '{0, 8'h04, 3};
    for (int i = 0; i < 5; i++) begin
      do_reset();
      sb_en = 1;
      push_pkt(vt[i].ch, vt[i].hdr);
      plan();
      run_done(400, 100);
      chk("single_beats", beats, vt[i].beats);
      chk("single_grant", s_grant, vt[i].ch);
      chk("single_busy_drop", cyc - last_hs_cyc, 2);
      chk("single_no_soft_reset", sr_seen, 0);
    end

    // Round-robin: all three, then refill 0 and 2
    rr_exp = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd2};
    do_reset();
    push_pkt(0, 8'h04); push_pkt(1, 8'h05); push_pkt(2, 8'h06);
    plan();
    run_done(200, 100);
    push_pkt(0, 8'h07); push_pkt(2, 8'h04);
    plan();
    run_done(200, 100);
    chk("rr_count", got_grants.size(), 5);
    for (int i = 0; i < 5 && i < got_grants.size(); i++) chk("rr_grant_seq", got_grants[i], rr_exp[i]);

    // Backpressure: 10 cycles of out_ready low mid-packet
    do_reset();
    hold_chk = 1;
    push_pkt(1, 8'h18);
    plan();
    out_ready = 1'b1;
    n = 0;
    while (hs_cnt < 3 && n < 100) begin tick(); n++; end
    out_ready = 1'b0;
    repeat (10) tick();
    run_done(200, 100);
    hold_chk = 0;
    chk("bp_beats", beats, 8);
    chk("bp_no_soft_reset", sr_seen, 0);

    // Timeout: FIFO2 stalls after its 2nd beat, FIFO0 must be served next
    do_reset();
    push_pkt(1, 8'h04);
    plan();
    run_done(200, 100);
    chk("to_grant_before", s_grant, 1);
    sb_en = 0;
    push_pkt(2, 8'h14);
    push_pkt(0, 8'h08);
    pq0.delete(); pq2.delete();
    hs_cnt = 0; stall = 0; n = 0;
    s_sr = 3'b000;
    while (s_sr == 3'b000 && n < 300) begin
      out_ready = (hs_cnt < 2);
      tick();
      n++;
      if (s_valid && !s_ready) stall++;
    end
    chk("to_stall_cycles", stall, 30);
    chk("to_soft_reset_ch", s_sr, 3'b100);
    chk("to_valid_dropped", s_valid, 0);
    chk("to_grant_held", s_grant, 2);
    chk("to_beats_before_abort", hs_cnt, 2);
    tick();
    chk("to_soft_reset_one_cycle", s_sr, 0);
    out_ready = 1'b1;
    hs_cnt = 0; n = 0;
    while (hs_cnt == 0 && n < 50) begin tick(); n++; end
    chk("to_next_grant", s_grant, 0);
    chk("to_next_header", s_data, 8'h08);

    // Reset in the middle of a transfer
    do_reset();
    push_pkt(1, 8'h18);
    out_ready = 1'b1;
    n = 0;
    while (hs_cnt < 2 && n < 100) begin tick(); n++; end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    clear_all();
    tick();
    chk("mrst_valid", s_valid, 0);
    chk("mrst_read_enb", s_rd, 0);
    chk("mrst_busy", s_busy, 0);
    chk("mrst_out_data", s_data, 0);
    chk("mrst_grant", s_grant, 2);
    repeat (3) tick();
    chk("mrst_no_soft_reset", sr_seen, 0);

    // Randomized packets and backpressure against the round-robin packet model
    do_reset();
    sb_en = 1;
    for (int r = 0; r < 10; r++) begin
      for (int ch = 0; ch < 3; ch++) begin
        n = $urandom_range(0, 2);
        for (int p = 0; p < n; p++)
          push_pkt(ch, {6'($urandom_range(0, 12)), 2'($urandom_range(0, 3))});
      end
      plan();
      run_done(3000, 75);
    end
    chk("rand_no_soft_reset", sr_seen, 0);
    chk("no_bad_reads", bad_read, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
